// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from a combinational instruction memory
// into a small prefetch FIFO, and hands instructions to decode (valid/ready).
// Optional halt-on-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               push;
  logic               pop;
  logic               halt_hit;

  // Memory address is the live PC; head entry is read straight from storage.
  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // Redirect wins over both sides; a full FIFO may still accept a push when
  // the head leaves in the same cycle.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & ~halted & ((count < DEPTH_C) | pop);

`ifdef FETCH_HALT_EN
  logic halted_q;

  assign halt_hit = push && (imem_data[INSTR_W-1 -: 4] == HALT_OP);
  assign halted   = halted_q;

  // Halt latches when the halt opcode is enqueued; only redirect or reset clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (halt_hit) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // PC, FIFO storage, pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= pc;
        instr_mem[wr_ptr] <= imem_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        // A halt instruction parks the PC on its own address.
        if (!halt_hit) begin
          pc <= pc + ADDR_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit reset, streaming, back-pressure,
// redirect flush/wrap and (with FETCH_HALT_EN) halt behaviour.
// Memory model: word at address a is a ^ 16'h5A00 (word 3 is 16'hF000 in halt mode).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        halt_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_data = (halt_mode && imem_addr == 16'd3) ? 16'hF000 : (imem_addr ^ 16'h5A00);

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Hold reset, check reset state, then release; the next rising edge ends cycle 0.
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    out_ready = rdy;
    cyc();
    cyc();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc",    {16'b0, out_pc},    32'd0);
    chk("rst_instr", {16'b0, out_instr}, 32'd0);
    chk("rst_addr",  {16'b0, imem_addr}, 32'd0);
    chk("rst_halt",  {31'b0, halted},    32'd0);
    rst = 1'b0;
  endtask

  initial begin
    halt_mode = 1'b0;

    // Streaming from reset with decode always ready.
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_pc",    {16'b0, out_pc},    32'(k - 1));
      chk("stream_instr", {16'b0, out_instr}, {16'b0, 16'(k - 1) ^ 16'h5A00});
    end

    // Back-pressure from reset: FIFO fills to 2 and PC parks at 2.
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_pc",    {16'b0, out_pc},    32'd0);
      chk("bp_addr",  {16'b0, imem_addr}, (k == 1) ? 32'd1 : 32'd2);
    end
    out_ready = 1'b1;
    // Full FIFO draining and refilling every cycle: head advances by one, PC stays 2 ahead.
    for (int j = 1; j <= 4; j++) begin
      cyc();
      chk("full_valid", {31'b0, out_valid}, 32'd1);
      chk("full_pc",    {16'b0, out_pc},    32'(j));
      chk("full_instr", {16'b0, out_instr}, {16'b0, 16'(j) ^ 16'h5A00});
      chk("full_addr",  {16'b0, imem_addr}, 32'(j + 2));
    end

    // Redirect while full with decode ready: old entries are dropped.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_n1_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_n1_addr",  {16'b0, imem_addr}, 32'h40);
    cyc();
    chk("redir_n2_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_n2_pc",    {16'b0, out_pc},    32'h40);
    chk("redir_n2_instr", {16'b0, out_instr}, 32'h5A40);
    cyc();
    chk("redir_n3_pc",    {16'b0, out_pc},    32'h41);

    // Redirect near the top of the address space: PC wraps to zero.
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    chk("wrap_n1_valid", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("wrap_valid", {31'b0, out_valid}, 32'd1);
      chk("wrap_pc",    {16'b0, out_pc},    {16'b0, 16'hFFFE + 16'(k)});
    end

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    cyc();
    redirect_pc = 16'h0200;
    chk("b2b_n1_valid", {31'b0, out_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    chk("b2b_n2_valid", {31'b0, out_valid}, 32'd0);
    chk("b2b_n2_addr",  {16'b0, imem_addr}, 32'h200);
    cyc();
    chk("b2b_n3_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_n3_pc",    {16'b0, out_pc},    32'h200);

`ifdef FETCH_HALT_EN
    // Word 3 is a halt: 0..3 delivered, then fetch parks at 3 until redirected.
    halt_mode = 1'b1;
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("halt_valid", {31'b0, out_valid}, 32'd1);
      chk("halt_pc",    {16'b0, out_pc},    32'(k - 1));
    end
    chk("halt_instr", {16'b0, out_instr}, 32'hF000);
    chk("halt_flag",  {31'b0, halted},    32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("halt_drained", {31'b0, out_valid}, 32'd0);
      chk("halt_addr",    {16'b0, imem_addr}, 32'd3);
      chk("halt_hold",    {31'b0, halted},    32'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    cyc();
    redirect_valid = 1'b0;
    chk("unhalt_flag",  {31'b0, halted},    32'd0);
    chk("unhalt_addr",  {16'b0, imem_addr}, 32'h10);
    cyc();
    chk("unhalt_valid", {31'b0, out_valid}, 32'd1);
    chk("unhalt_pc",    {16'b0, out_pc},    32'h10);
    cyc();
    chk("unhalt_next",  {16'b0, out_pc},    32'h11);
`else
    chk("halt_tied", {31'b0, halted}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory's 16-bit word address.
- It captures the 16-bit instruction returned combinationally in the same cycle into a small prefetch FIFO.
- It presents instructions to decode over a valid/ready handshake.
- It handles redirects (branch/jump) with a FIFO flush.

Parameters:
- ADDR_W, 16, PC / memory address width (word addressed, +1 per instruction)
- INSTR_W, 16, instruction width
- DEPTH, 2, prefetch FIFO entries (power of two, >=2)
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_OP, 4'hF, opcode (instr[15:12]) treated as halt when FETCH_HALT_EN is defined

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_addr  output  ADDR_W  address to instruction memory; equals current PC
- imem_data  input  INSTR_W  instruction memory read data, combinational from imem_addr
- redirect_valid  input  1  load redirect_pc and flush FIFO
- redirect_pc  input  ADDR_W  redirect target
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode accepts head
- out_instr  output  INSTR_W  head instruction
- out_pc  output  ADDR_W  PC of head instruction
- halted  output  1  fetch halted (tied 0 without FETCH_HALT_EN)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - pc=RESET_PC, FIFO empty (count=0, rd/wr ptr=0), halted=0.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
  - Reset overrides redirect and all handshake activity in the same cycle.
- imem_addr = pc, combinationally.
- Each FIFO entry holds {pc, imem_data}.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & ~halted & (count<DEPTH | pop).
- On push:
  - The entry is written at wr_ptr, and wr_ptr increments.
  - pc <= pc+1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000).
- On pop: rd_ptr increments.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Push and pop in the same cycle when full is legal.
- out_valid = (count!=0). out_instr/out_pc = entry at rd_ptr, driven from registers.
- Pointers wrap modulo DEPTH. When empty, out_instr/out_pc show stale data and must not be sampled.
- Redirect (redirect_valid=1 in cycle N):
  - Priority over push/pop. Any decode handshake in cycle N is ignored (not consumed).
  - End of N: count=0, rd_ptr=wr_ptr=0, pc<=redirect_pc, halted<=0.
  - N+1: imem_addr=redirect_pc and it is pushed. N+2: out_valid=1 with out_pc=redirect_pc.
  - Redirect-to-valid latency is 2 cycles.
- Reset release: the first push occurs at the end of cycle 0. out_valid=1 in cycle 1 with out_pc=RESET_PC.
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- Back-pressure: with out_ready=0, the FIFO fills to DEPTH and then pc holds. Nothing is lost or duplicated.
- Back-to-back redirects: each redirect flushes; the last one wins.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - When a push writes an instruction with imem_data[15:12]==HALT_OP, halted<=1 and pc does NOT increment; it stays at the halt address.
  - The halt instruction itself is enqueued and delivered normally.
  - While halted: no pushes and pc frozen. The FIFO still drains to decode.
  - Cleared only by redirect or rst.
- Undefined: no opcode inspection, and halted is tied 0.

Test Plan:
- Reset then out_ready=1, memory holds word n at address n: out_pc=0,1,2,3 on cycles 1..4 with out_instr matching, out_valid continuously 1.
- out_ready=0 from reset for 5 cycles: count saturates at 2 and pc holds at 2. Raise out_ready: pcs 0,1,2,3 delivered in order, no gaps, no repeats.
- FIFO full plus out_ready=1 held steady: a push and a pop happen every cycle, count stays 2, and out_pc increments by 1 per cycle.
- redirect_valid=1, redirect_pc=16'h0040 while FIFO holds 2 entries with out_ready=1:
  - Cycle N+1: out_valid=0.
  - Cycle N+2: out_pc=16'h0040.
  - The old entries are never popped.
- Redirect to 16'hFFFE with out_ready=1: out_pc sequence FFFE, FFFF, 0000, 0001 (wrap).
- With FETCH_HALT_EN, word 3 = 16'hF000:
  - pcs 0..3 are delivered, halted=1, imem_addr holds 3, and no further valid once drained.
  - redirect_pc=16'h0010 clears halted, and fetch resumes at 16'h0010.
